// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: one-entry holds for requesters A/B share the reg_file write port; hold->WRITEENABLE in 1 cycle, 1 write/cycle.
// REQx_READY is low while that hold is full. WR_ARB_FIXED_PRIO_EN: same-edge ties always grant A (no round-robin pointer).
module reg_write_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  REQA_VALID,
    input  logic [ADDR_WIDTH-1:0] REQA_REG,
    input  logic [DATA_WIDTH-1:0] REQA_DATA,
    output logic                  REQA_READY,
    input  logic                  REQB_VALID,
    input  logic [ADDR_WIDTH-1:0] REQB_REG,
    input  logic [DATA_WIDTH-1:0] REQB_DATA,
    output logic                  REQB_READY,
    input  logic [ADDR_WIDTH-1:0] READREG1,
    input  logic [ADDR_WIDTH-1:0] READREG2,
    output logic [ADDR_WIDTH-1:0] WRITEREG,
    output logic [DATA_WIDTH-1:0] WRITEDATA,
    output logic                  WRITEENABLE,
    output logic                  PEND_HIT1,
    output logic                  PEND_HIT2,
    output logic                  BUSY
);

    logic                  hold_valid_a;
    logic [ADDR_WIDTH-1:0] hold_reg_a;
    logic [DATA_WIDTH-1:0] hold_data_a;
    logic                  hold_valid_b;
    logic [ADDR_WIDTH-1:0] hold_reg_b;
    logic [DATA_WIDTH-1:0] hold_data_b;

    // age_b_older: B was captured before A; tie: both captured on the same edge
    logic age_b_older;
    logic tie;
`ifndef WR_ARB_FIXED_PRIO_EN
    logic rr_ptr;
`endif

    logic accept_a;
    logic accept_b;
    logic grant_a;
    logic grant_b;

    assign REQA_READY = ~hold_valid_a;
    assign REQB_READY = ~hold_valid_b;
    assign accept_a   = REQA_VALID & ~hold_valid_a;
    assign accept_b   = REQB_VALID & ~hold_valid_b;

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (hold_valid_a && hold_valid_b) begin
            if (tie) begin
`ifdef WR_ARB_FIXED_PRIO_EN
                grant_a = 1'b1;
`else
                grant_a = ~rr_ptr;
                grant_b = rr_ptr;
`endif
            end else begin
                grant_a = ~age_b_older;
                grant_b = age_b_older;
            end
        end else begin
            grant_a = hold_valid_a;
            grant_b = hold_valid_b;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hold_valid_a <= 1'b0;
            hold_reg_a   <= '0;
            hold_data_a  <= '0;
        end else begin
            hold_valid_a <= accept_a | (hold_valid_a & ~grant_a);
            if (accept_a) begin
                hold_reg_a  <= REQA_REG;
                hold_data_a <= REQA_DATA;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hold_valid_b <= 1'b0;
            hold_reg_b   <= '0;
            hold_data_b  <= '0;
        end else begin
            hold_valid_b <= accept_b | (hold_valid_b & ~grant_b);
            if (accept_b) begin
                hold_reg_b  <= REQB_REG;
                hold_data_b <= REQB_DATA;
            end
        end
    end

    // Ordering state: the survivor of the other side becomes the older entry
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            age_b_older <= 1'b0;
            tie         <= 1'b0;
        end else begin
            tie <= accept_a & accept_b;
            if (accept_a && hold_valid_b && !grant_b) begin
                age_b_older <= 1'b1;
            end else if (accept_b && hold_valid_a && !grant_a) begin
                age_b_older <= 1'b0;
            end
        end
    end

`ifndef WR_ARB_FIXED_PRIO_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rr_ptr <= 1'b0;
        end else if (hold_valid_a && hold_valid_b && tie) begin
            rr_ptr <= ~rr_ptr;
        end
    end
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            WRITEENABLE <= 1'b0;
            WRITEREG    <= '0;
            WRITEDATA   <= '0;
        end else begin
            WRITEENABLE <= grant_a | grant_b;
            if (grant_a) begin
                WRITEREG  <= hold_reg_a;
                WRITEDATA <= hold_data_a;
            end else if (grant_b) begin
                WRITEREG  <= hold_reg_b;
                WRITEDATA <= hold_data_b;
            end
        end
    end

    assign PEND_HIT1 = (hold_valid_a && hold_reg_a == READREG1) ||
                       (hold_valid_b && hold_reg_b == READREG1) ||
                       (WRITEENABLE  && WRITEREG   == READREG1);
    assign PEND_HIT2 = (hold_valid_a && hold_reg_a == READREG2) ||
                       (hold_valid_b && hold_reg_b == READREG2) ||
                       (WRITEENABLE  && WRITEREG   == READREG2);
    assign BUSY      = hold_valid_a | hold_valid_b | WRITEENABLE;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed vector table, reset/throughput sequences, and a random run against a queue model.
module tb_reg_write_arbiter;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       REQA_VALID, REQB_VALID;
    logic [2:0] REQA_REG, REQB_REG, READREG1, READREG2;
    logic [7:0] REQA_DATA, REQB_DATA;
    logic       REQA_READY, REQB_READY;
    logic [2:0] WRITEREG;
    logic [7:0] WRITEDATA;
    logic       WRITEENABLE, PEND_HIT1, PEND_HIT2, BUSY;

    always #5 CLK = ~CLK;

    reg_write_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
        .CLK(CLK), .RESET(RESET),
        .REQA_VALID(REQA_VALID), .REQA_REG(REQA_REG), .REQA_DATA(REQA_DATA), .REQA_READY(REQA_READY),
        .REQB_VALID(REQB_VALID), .REQB_REG(REQB_REG), .REQB_DATA(REQB_DATA), .REQB_READY(REQB_READY),
        .READREG1(READREG1), .READREG2(READREG2),
        .WRITEREG(WRITEREG), .WRITEDATA(WRITEDATA), .WRITEENABLE(WRITEENABLE),
        .PEND_HIT1(PEND_HIT1), .PEND_HIT2(PEND_HIT2), .BUSY(BUSY)
    );

    // reg_file stand-in: writes on the posedge after WRITEENABLE is driven
    logic [7:0] rf [8] = '{default: 8'd0};
    always @(posedge CLK) if (WRITEENABLE) rf[WRITEREG] <= WRITEDATA;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string tag, input logic we, input logic [2:0] wreg, input logic [7:0] wdata,
                             input logic rdya, input logic rdyb, input logic h1, input logic h2, input logic busy);
        check({tag, "/we"},    32'(WRITEENABLE), 32'(we));
        check({tag, "/wreg"},  32'(WRITEREG),    32'(wreg));
        check({tag, "/wdata"}, 32'(WRITEDATA),   32'(wdata));
        check({tag, "/rdya"},  32'(REQA_READY),  32'(rdya));
        check({tag, "/rdyb"},  32'(REQB_READY),  32'(rdyb));
        check({tag, "/hit1"},  32'(PEND_HIT1),   32'(h1));
        check({tag, "/hit2"},  32'(PEND_HIT2),   32'(h2));
        check({tag, "/busy"},  32'(BUSY),        32'(busy));
    endtask

    typedef struct {
        logic va; logic [2:0] ra; logic [7:0] da;
        logic vb; logic [2:0] rb; logic [7:0] db;
        logic [2:0] rr1; logic [2:0] rr2;
        logic we; logic [2:0] wreg; logic [7:0] wdata;
        logic rdya; logic rdyb; logic h1; logic h2; logic busy;
    } vec_t;

    function automatic vec_t mk(input logic va, input logic [2:0] ra, input logic [7:0] da,
                                input logic vb, input logic [2:0] rb, input logic [7:0] db,
                                input logic [2:0] rr1, input logic [2:0] rr2,
                                input logic we, input logic [2:0] wreg, input logic [7:0] wdata,
                                input logic rdya, input logic rdyb, input logic h1, input logic h2,
                                input logic busy);
        vec_t v;
        v.va = va; v.ra = ra; v.da = da; v.vb = vb; v.rb = rb; v.db = db;
        v.rr1 = rr1; v.rr2 = rr2; v.we = we; v.wreg = wreg; v.wdata = wdata;
        v.rdya = rdya; v.rdyb = rdyb; v.h1 = h1; v.h2 = h2; v.busy = busy;
        return v;
    endfunction

    // Behavioural model: pending writes in acceptance order, one retired per edge
    typedef struct { logic src; logic [2:0] r; logic [7:0] d; } ent_t;
    ent_t       pq[$];
    logic       m_we;
    logic [2:0] m_wreg;
    logic [7:0] m_wdata;
    logic       m_rr;

    function automatic logic has_src(input logic s);
        foreach (pq[i]) if (pq[i].src == s) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_hit(input logic [2:0] x);
        foreach (pq[i]) if (pq[i].r == x) return 1'b1;
        return m_we && (m_wreg == x);
    endfunction

    task automatic idle_inputs();
        REQA_VALID = 1'b0; REQA_REG = 3'd0; REQA_DATA = 8'd0;
        REQB_VALID = 1'b0; REQB_REG = 3'd0; REQB_DATA = 8'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        pq.delete(); m_we = 1'b0; m_wreg = 3'd0; m_wdata = 8'd0; m_rr = 1'b0;
    endtask

    task automatic reset_pulse(input string tag);
        #1 RESET = 1'b1;
        #2;
        check({tag, "/we"},   32'(WRITEENABLE), 32'd0);
        check({tag, "/rdya"}, 32'(REQA_READY),  32'd1);
        check({tag, "/rdyb"}, 32'(REQB_READY),  32'd1);
        check({tag, "/busy"}, 32'(BUSY),        32'd0);
        check({tag, "/hit1"}, 32'(PEND_HIT1),   32'd0);
        #1 RESET = 1'b0;
    endtask

    vec_t tbl[19];
    logic acc_a, acc_b;
    ent_t e;

    initial begin
        // Default build: 2nd tie goes to B; fixed-priority build: always A first
`ifdef WR_ARB_FIXED_PRIO_EN
        localparam logic [2:0] T1R = 3'd2, T2R = 3'd3;
        localparam logic [7:0] T1D = 8'd16, T2D = 8'd51;
        localparam logic T1A = 1'b1, T1B = 1'b0, T2H1 = 1'b0, T2H2 = 1'b1;
`else
        localparam logic [2:0] T1R = 3'd3, T2R = 3'd2;
        localparam logic [7:0] T1D = 8'd51, T2D = 8'd16;
        localparam logic T1A = 1'b0, T1B = 1'b1, T2H1 = 1'b1, T2H2 = 1'b0;
`endif
        tbl[0]  = mk(0,0,0,    0,0,0,    0,0, 0,0,0,     1,1,0,0,0);
        tbl[1]  = mk(1,1,28,   0,0,0,    1,5, 0,0,0,     0,1,1,0,1);
        tbl[2]  = mk(0,0,0,    0,0,0,    1,5, 1,1,28,    1,1,1,0,1);
        tbl[3]  = mk(0,0,0,    0,0,0,    1,5, 0,1,28,    1,1,0,0,0);
        tbl[4]  = mk(1,2,15,   1,3,50,   2,3, 0,1,28,    0,0,1,1,1);
        tbl[5]  = mk(0,0,0,    0,0,0,    2,3, 1,2,15,    1,0,1,1,1);
        tbl[6]  = mk(0,0,0,    0,0,0,    2,3, 1,3,50,    1,1,0,1,1);
        tbl[7]  = mk(0,0,0,    0,0,0,    2,3, 0,3,50,    1,1,0,0,0);
        tbl[8]  = mk(1,2,16,   1,3,51,   2,3, 0,3,50,    0,0,1,1,1);
        tbl[9]  = mk(0,0,0,    0,0,0,    2,3, 1,T1R,T1D, T1A,T1B,1,1,1);
        tbl[10] = mk(0,0,0,    0,0,0,    2,3, 1,T2R,T2D, 1,1,T2H1,T2H2,1);
        tbl[11] = mk(0,0,0,    0,0,0,    2,3, 0,T2R,T2D, 1,1,0,0,0);
        tbl[12] = mk(0,0,0,    1,4,7,    4,5, 0,T2R,T2D, 1,0,1,0,1);
        tbl[13] = mk(1,4,9,    0,0,0,    4,5, 1,4,7,     0,1,1,0,1);
        tbl[14] = mk(0,0,0,    0,0,0,    4,5, 1,4,9,     1,1,1,0,1);
        tbl[15] = mk(0,0,0,    0,0,0,    4,5, 0,4,9,     1,1,0,0,0);
        tbl[16] = mk(0,0,0,    1,4,8,    4,5, 0,4,9,     1,0,1,0,1);
        tbl[17] = mk(0,0,0,    0,0,0,    4,5, 1,4,8,     1,1,1,0,1);
        tbl[18] = mk(0,0,0,    0,0,0,    4,5, 0,4,8,     1,1,0,0,0);

        idle_inputs();
        READREG1 = 3'd0; READREG2 = 3'd0;
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check_out("reset", 0, 0, 0, 1, 1, 0, 0, 0);
        RESET = 1'b0;

        for (int i = 0; i < 19; i++) begin
            REQA_VALID = tbl[i].va; REQA_REG = tbl[i].ra; REQA_DATA = tbl[i].da;
            REQB_VALID = tbl[i].vb; REQB_REG = tbl[i].rb; REQB_DATA = tbl[i].db;
            READREG1 = tbl[i].rr1; READREG2 = tbl[i].rr2;
            @(posedge CLK); #1;
            check_out($sformatf("vec%0d", i), tbl[i].we, tbl[i].wreg, tbl[i].wdata,
                      tbl[i].rdya, tbl[i].rdyb, tbl[i].h1, tbl[i].h2, tbl[i].busy);
            if (i == 3)  check("rf_r1", 32'(rf[1]), 32'd28);
            if (i == 7)  check("rf_r3", 32'(rf[3]), 32'd50);
            if (i == 15) check("rf_r4_order", 32'(rf[4]), 32'd9);
        end

        // Reset while a write is issuing and B is held: nothing may land in R6/R7
        do_reset();
        READREG1 = 3'd7; READREG2 = 3'd6;
        REQA_VALID = 1'b1; REQA_REG = 3'd6; REQA_DATA = 8'd99;
        @(posedge CLK); #1;
        REQA_VALID = 1'b0;
        REQB_VALID = 1'b1; REQB_REG = 3'd7; REQB_DATA = 8'd77;
        @(posedge CLK); #1;
        check("rst1_pre_we", 32'(WRITEENABLE), 32'd1);
        REQB_VALID = 1'b0;
        reset_pulse("rst1");
        repeat (2) @(posedge CLK);
        #1;
        check("rst1_rf6", 32'(rf[6]), 32'd0);
        check("rst1_rf7", 32'(rf[7]), 32'd0);

        // Both holds valid, then reset
        REQA_VALID = 1'b1; REQA_REG = 3'd6; REQA_DATA = 8'd11;
        REQB_VALID = 1'b1; REQB_REG = 3'd7; REQB_DATA = 8'd22;
        @(posedge CLK); #1;
        idle_inputs();
        check("rst2_pre_busy", 32'(BUSY), 32'd1);
        reset_pulse("rst2");
        repeat (2) @(posedge CLK);
        #1;
        check("rst2_we", 32'(WRITEENABLE), 32'd0);
        check("rst2_rf6", 32'(rf[6]), 32'd0);
        check("rst2_rf7", 32'(rf[7]), 32'd0);

        // Streaming producer on A: accepts every other edge, data 1,2,3... in order
        do_reset();
        begin
            logic [7:0] seq;
            seq = 8'd1;
            for (int k = 0; k < 12; k++) begin
                REQA_VALID = 1'b1; REQA_REG = 3'd1; REQA_DATA = seq;
                acc_a = REQA_READY;
                @(posedge CLK); #1;
                if (acc_a) seq = seq + 8'd1;
                check($sformatf("strm%0d/we", k),  32'(WRITEENABLE), 32'(k % 2 == 1));
                check($sformatf("strm%0d/rdy", k), 32'(REQA_READY),  32'(k % 2 == 1));
                if (k % 2 == 1) check($sformatf("strm%0d/data", k), 32'(WRITEDATA), 32'((k + 1) / 2));
            end
            REQA_VALID = 1'b0;
        end

        // Random traffic against the queue model
        do_reset();
        for (int c = 0; c < 600; c++) begin
            REQA_VALID = 1'($urandom_range(0, 1));
            REQA_REG   = 3'($urandom_range(0, 7));
            REQA_DATA  = 8'($urandom_range(0, 255));
            REQB_VALID = 1'($urandom_range(0, 1));
            REQB_REG   = 3'($urandom_range(0, 7));
            REQB_DATA  = 8'($urandom_range(0, 255));
            READREG1   = 3'($urandom_range(0, 7));
            READREG2   = 3'($urandom_range(0, 7));
            acc_a = REQA_VALID && !has_src(1'b0);
            acc_b = REQB_VALID && !has_src(1'b1);
            @(posedge CLK);
            if (pq.size() > 0) begin
                e = pq.pop_front();
                m_we = 1'b1; m_wreg = e.r; m_wdata = e.d;
            end else begin
                m_we = 1'b0;
            end
            if (acc_a && acc_b) begin
`ifdef WR_ARB_FIXED_PRIO_EN
                pq.push_back('{1'b0, REQA_REG, REQA_DATA});
                pq.push_back('{1'b1, REQB_REG, REQB_DATA});
`else
                if (!m_rr) begin
                    pq.push_back('{1'b0, REQA_REG, REQA_DATA});
                    pq.push_back('{1'b1, REQB_REG, REQB_DATA});
                end else begin
                    pq.push_back('{1'b1, REQB_REG, REQB_DATA});
                    pq.push_back('{1'b0, REQA_REG, REQA_DATA});
                end
                m_rr = ~m_rr;
`endif
            end else if (acc_a) begin
                pq.push_back('{1'b0, REQA_REG, REQA_DATA});
            end else if (acc_b) begin
                pq.push_back('{1'b1, REQB_REG, REQB_DATA});
            end
            #1;
            check_out($sformatf("rnd%0d", c), m_we, m_wreg, m_wdata, !has_src(1'b0), !has_src(1'b1),
                      m_hit(READREG1), m_hit(READREG2), (pq.size() > 0) || m_we);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
